// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter sharing one combinational sprite palette
// among NREQ pixel requesters, with a registered valid/ready response.
module palette_lookup_arbiter #(
  parameter int NREQ       = 4,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0,
  localparam int ID_W      = $clog2(NREQ)
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*IDX_W-1:0] req_index,
  output logic [NREQ-1:0]       req_ready,
  output logic [IDX_W-1:0]      pal_index,
  input  logic [3:0]            pal_red,
  input  logic [3:0]            pal_green,
  input  logic [3:0]            pal_blue,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [3:0]            rsp_red,
  output logic [3:0]            rsp_green,
  output logic [3:0]            rsp_blue,
  output logic                  rsp_transparent
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] ptr_next;
  logic            any;
  logic            can_accept;
  logic            accept;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      int cand;
      cand = (int'(ptr) + k) % NREQ;
      if (!any && req_valid[cand]) begin
        any    = 1'b1;
        winner = ID_W'(cand);
      end
    end
  end

  assign can_accept = !rsp_valid || rsp_ready;
  // Reset gates the grant so nothing looks accepted while held in reset.
  assign accept     = can_accept && any && Reset_n;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_comb begin
    pal_index = '0;
    if (any) pal_index = req_index[int'(winner)*IDX_W +: IDX_W];
  end

  always_comb begin
    ptr_next = winner + ID_W'(1);
    if (winner == ID_W'(NREQ-1)) ptr_next = '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr             <= '0;
      rsp_valid       <= 1'b0;
      rsp_id          <= '0;
      rsp_red         <= '0;
      rsp_green       <= '0;
      rsp_blue        <= '0;
      rsp_transparent <= 1'b0;
    end else if (accept) begin
      ptr             <= ptr_next;
      rsp_valid       <= 1'b1;
      rsp_id          <= winner;
      rsp_red         <= pal_red;
      rsp_green       <= pal_green;
      rsp_blue        <= pal_blue;
      rsp_transparent <= (pal_index == IDX_W'(TRANSP_IDX));
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
